// File: rtl/uart_receiver.sv
// 8N1 UART receiver: double-synchronised rx, mid-bit sampling, one-cycle valid or
// framing-error pulse per frame, and a BREAK state that absorbs a held-low line.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] serial_input_data,
  output logic       serial_input_valid,
  output logic       framing_error
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt;
  logic             error_nxt;
  logic             rx_meta;
  logic             rx_s;

  // The line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would chain rx_meta straight into rx_s.
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      clk_cnt            <= '0;
      bit_cnt            <= '0;
      shift              <= '0;
      serial_input_data  <= '0;
      serial_input_valid <= 1'b0;
      framing_error      <= 1'b0;
    end else begin
      state              <= state_nxt;
      clk_cnt            <= clk_cnt_nxt;
      bit_cnt            <= bit_cnt_nxt;
      shift              <= shift_nxt;
      serial_input_data  <= data_nxt;
      serial_input_valid <= valid_nxt;
      framing_error      <= error_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that leaves one
    // unassigned would infer a latch.
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    data_nxt    = serial_input_data;
    valid_nxt   = 1'b0;
    error_nxt   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_nxt   = S_START;
          clk_cnt_nxt = '0;
        end
      end

      // Re-check at mid start bit so short glitches are rejected.
      S_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_s, shift[7:1]};
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            state_nxt = S_STOP;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      // Leaving at mid stop bit leaves half a bit of slack for the next start edge.
      S_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            error_nxt = 1'b1;
            state_nxt = S_BREAK;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end

      S_BREAK: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
